// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock: state encoding and the symbol-width
// helper that the display controller also uses to decode state.
package lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    PROGRAM = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  // Bits per code symbol; a single button still needs one bit.
  function automatic int sw_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/param_digital_lock.sv
// Keypad lock: matches a CODE_LEN-symbol entry against a stored code, with
// failed-attempt lockout, timed auto-relock and in-field code reprogramming.
module param_digital_lock
  import lock_pkg::*;
#(
  parameter int                                         NUM_BUTTONS    = 4,
  parameter int                                         CODE_LEN       = 4,
  parameter logic [CODE_LEN*sw_width(NUM_BUTTONS)-1:0]  DEFAULT_CODE   = 8'hE4,
  parameter int                                         MAX_FAILS      = 3,
  parameter int                                         UNLOCK_CYCLES  = 1_000_000,
  parameter int                                         LOCKOUT_CYCLES = 10_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BUTTONS-1:0]            btn_pulse,
  input  logic                              clr,
  input  logic                              prog_req,
  output logic                              unlocked,
  output logic                              locked_out,
  output logic                              prog_mode,
  output logic                              error,
  output logic [$clog2(CODE_LEN+1)-1:0]     digits_entered,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count
);

  localparam int SW = sw_width(NUM_BUTTONS);
  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int CW = CODE_LEN * SW;
  localparam int TW = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t   state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic          mis_q, mis_n;
  logic [FW-1:0] fail_q, fail_n;
  logic [CW-1:0] code_q, code_n;
  logic [CW-1:0] shadow_q, shadow_n;
  logic          err_q, err_n;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  logic          press;
  logic          bad;
  logic [SW-1:0] sym;
  logic [SW-1:0] code_sym;
  logic [CW-1:0] shadow_w;
  logic          last;
  logic          sym_mis;
  logic [FW-1:0] fail_inc;

  // Press classification: more than one bit set is a bad press.
  assign press = |btn_pulse;
  assign bad   = ($countones(btn_pulse) > 1);

  always_comb begin
    sym = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (btn_pulse[i]) sym = i[SW-1:0];
    end
  end

  always_comb begin
    code_sym = '0;
    shadow_w = shadow_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IW'(i)) begin
        code_sym               = code_q[i*SW +: SW];
        shadow_w[i*SW +: SW]   = sym;
      end
    end
  end

  assign last     = (idx_q == IW'(CODE_LEN - 1));
  assign sym_mis  = bad || (sym != code_sym);
  assign fail_inc = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

  lock_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .enable     (state_q != ENTRY),
    .done       (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ENTRY;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      fail_q   <= '0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      mis_q    <= mis_n;
      fail_q   <= fail_n;
      code_q   <= code_n;
      shadow_q <= shadow_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    mis_n     = mis_q;
    fail_n    = fail_q;
    code_n    = code_q;
    shadow_n  = shadow_q;
    err_n     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = UNLOCK_LOAD;
    case (state_q)
      ENTRY: begin
        if (clr) begin
          idx_n = '0;
          mis_n = 1'b0;
        end else if (press) begin
          if (last) begin
            idx_n = '0;
            mis_n = 1'b0;
            if (!(mis_q || sym_mis)) begin
              state_n  = OPEN;
              fail_n   = '0;
              tmr_load = 1'b1;
            end else begin
              err_n  = 1'b1;
              fail_n = fail_inc;
              if (fail_inc == FW'(MAX_FAILS)) begin
                state_n   = LOCKOUT;
                tmr_load  = 1'b1;
                tmr_value = LOCKOUT_LOAD;
              end
            end
          end else begin
            idx_n = idx_q + 1'b1;
            mis_n = mis_q || sym_mis;
          end
        end
      end
      OPEN: begin
        // A program request wins over relock in the expiry cycle.
        if (prog_req) begin
          state_n  = PROGRAM;
          idx_n    = '0;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_n = ENTRY;
        end
      end
      PROGRAM: begin
        if (clr || (press && bad) || tmr_done) begin
          err_n   = 1'b1;
          state_n = ENTRY;
          idx_n   = '0;
        end else if (press) begin
          if (last) begin
            code_n  = shadow_w;
            state_n = ENTRY;
            idx_n   = '0;
          end else begin
            shadow_n = shadow_w;
            idx_n    = idx_q + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          state_n = ENTRY;
          fail_n  = '0;
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  assign unlocked       = (state_q == OPEN);
  assign locked_out     = (state_q == LOCKOUT);
  assign prog_mode      = (state_q == PROGRAM);
  assign error          = err_q;
  assign digits_entered = ((state_q == ENTRY) || (state_q == PROGRAM)) ? idx_q : '0;
  assign fail_count     = fail_q;

endmodule

// File: tb/tb_param_digital_lock.sv
// Bench for param_digital_lock: directed button sequences push expected
// {cycle, status} records; a negedge monitor pops one whenever the status changes.
module tb_param_digital_lock;

  localparam int W        = 32;
  localparam int M_UNLOCK = 0;
  localparam int M_FAIL   = 1;
  localparam int M_PROG   = 2;
  localparam int M_NONE   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_pulse = '0;
  logic       clr = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, prog_mode, error;
  logic [2:0] digits_entered;
  logic [1:0] fail_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_last   = 0;
  bit mon_en   = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [5:0]   mon_prev = '0;
  logic [5:0]   mon_cur;
  logic [W-1:0] mon_got, mon_want;

  param_digital_lock #(
    .UNLOCK_CYCLES  (16),
    .LOCKOUT_CYCLES (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_pulse      (btn_pulse),
    .clr            (clr),
    .prog_req       (prog_req),
    .unlocked       (unlocked),
    .locked_out     (locked_out),
    .prog_mode      (prog_mode),
    .error          (error),
    .digits_entered (digits_entered),
    .fail_count     (fail_count)
  );

  // Clock and cycle counter
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] st(input logic u, input logic lo, input logic pm,
                                    input logic er, input int fc);
    return {u, lo, pm, er, fc[1:0]};
  endfunction

  task automatic push_abs(input int t, input logic [5:0] s);
    exp_q.push_back({26'(t), s});
  endtask

  task automatic push(input int dt, input logic [5:0] s);
    push_abs(cyc + dt, s);
  endtask

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Driver tasks: called at a negedge, return at the next negedge.
  task automatic drive(input logic [3:0] b, input logic c, input logic p);
    btn_pulse = b;
    clr       = c;
    prog_req  = p;
    @(negedge clk);
    btn_pulse = '0;
    clr       = 1'b0;
    prog_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // btns holds four button vectors, first press in the low nibble.
  task automatic enter_code(input logic [15:0] btns, input int mode, input int fc);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        t_last = cyc;
        case (mode)
          M_UNLOCK: push(1, st(1, 0, 0, 0, 0));
          M_FAIL: begin
            push(1, st(0, fc == 3, 0, 1, fc));
            push(2, st(0, fc == 3, 0, 0, fc));
          end
          M_PROG: push(1, st(0, 0, 0, 0, 0));
          default: ;
        endcase
      end
      drive(btns[i*4 +: 4], 1'b0, 1'b0);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {unlocked, locked_out, prog_mode, error, fail_count};
      if (mon_cur !== mon_prev) begin
        checks++;
        mon_got = {26'(cyc), mon_cur};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cycle=%0d status=%b required=none", cyc, mon_cur);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            failures++;
            $display("FAIL status_event actual(cycle=%0d status=%b) required(cycle=%0d status=%b)",
                     mon_got[31:6], mon_got[5:0], mon_want[31:6], mon_want[5:0]);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    #100000;
    failures++;
    checks++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    @(negedge clk);
    idle(3);
    check("reset_outputs", {unlocked, locked_out, prog_mode, error, digits_entered, fail_count}, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // 1: correct default code, 16-cycle unlock window
    enter_code(16'h8421, M_UNLOCK, 0);
    push_abs(t_last + 17, st(0, 0, 0, 0, 0));
    idle(20);
    check("t1_fail_count", fail_count, 0);

    // 2: three wrong codes -> lockout, input ignored, exit after 32 cycles
    enter_code(16'h8821, M_FAIL, 1);
    enter_code(16'h8821, M_FAIL, 2);
    enter_code(16'h8821, M_FAIL, 3);
    push_abs(t_last + 33, st(0, 0, 0, 0, 0));
    enter_code(16'h8421, M_NONE, 0);
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    check("t2_locked_mid", locked_out, 1);
    idle(30);
    check("t2_locked_after", locked_out, 0);
    check("t2_fail_after", fail_count, 0);

    // 4: bad press as second symbol
    enter_code(16'h8431, M_FAIL, 1);
    idle(2);

    // 3: partial entry, clr, full entry
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    check("t3_digits_partial", digits_entered, 2);
    drive(4'b0000, 1'b1, 1'b0);
    check("t3_digits_clr", digits_entered, 0);
    check("t3_fail_kept", fail_count, 1);
    enter_code(16'h8421, M_UNLOCK, 0);
    push_abs(t_last + 17, st(0, 0, 0, 0, 0));
    idle(20);

    // 5: reprogram to 3,3,2,1; old code fails, new code opens; reset restores default
    enter_code(16'h8421, M_UNLOCK, 0);
    idle(3);
    push(1, st(0, 0, 1, 0, 0));
    drive(4'b0000, 1'b0, 1'b1);
    enter_code(16'h2488, M_PROG, 0);
    enter_code(16'h8421, M_FAIL, 1);
    enter_code(16'h2488, M_UNLOCK, 0);
    push_abs(t_last + 17, st(0, 0, 0, 0, 0));
    idle(20);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    enter_code(16'h8421, M_UNLOCK, 0);
    push_abs(t_last + 17, st(0, 0, 0, 0, 0));
    idle(20);

    // 6: program timeout aborts, code unchanged; reset in lockout clears at once
    enter_code(16'h8421, M_UNLOCK, 0);
    idle(2);
    push(1, st(0, 0, 1, 0, 0));
    push(17, st(0, 0, 0, 1, 0));
    push(18, st(0, 0, 0, 0, 0));
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0100, 1'b0, 1'b0);
    check("t6_prog_digits", digits_entered, 1);
    idle(20);
    enter_code(16'h8421, M_UNLOCK, 0);
    push_abs(t_last + 17, st(0, 0, 0, 0, 0));
    idle(20);
    enter_code(16'h8821, M_FAIL, 1);
    enter_code(16'h8821, M_FAIL, 2);
    enter_code(16'h8821, M_FAIL, 3);
    idle(5);
    push(1, st(0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("t6_async_reset", {unlocked, locked_out, prog_mode, error, digits_entered, fail_count}, 0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(3);

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
